sevenseg_capture: RTL

SEVENSEG_CAPTURE -- requirements
Module: sevenseg_capture

---
 rtl/sevenseg_capture_pkg.sv | 53 +++++
 rtl/sevenseg_decode.sv | 22 ++
 rtl/sevenseg_capture.sv | 130 +++++++++++++
 3 files changed

// File: rtl/sevenseg_capture_pkg.sv
// Shared definitions for the seven-segment capture block: FSM encoding,
// sample layout, idle constants and the segment decode table.
package sevenseg_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    localparam logic [3:0] ENABLE_IDLE  = 4'hF;
    localparam logic [6:0] SEGS_IDLE    = 7'h7F;
    localparam logic       DECIMAL_IDLE = 1'b1;

    typedef struct packed {
        logic [3:0] enable;
        logic [6:0] segs;
        logic       decimal;
    } sample_t;

    localparam sample_t SAMPLE_IDLE = '{
        enable:  ENABLE_IDLE,
        segs:    SEGS_IDLE,
        decimal: DECIMAL_IDLE
    };

    // Active-high gfedcba patterns; entry n is the glyph for hex value n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic one_low(input logic [3:0] en);
        logic hit;
        case (en)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
            default:                            hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] en);
        logic [1:0] idx;
        casez (en)
            4'b???0: idx = 2'd0;
            4'b??01: idx = 2'd1;
            4'b?011: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Maps an active-high gfedcba segment pattern to its hex nibble; any
// pattern outside the glyph table is flagged illegal.
module sevenseg_decode
    import sevenseg_capture_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       illegal
);

    always_comb begin
        nibble  = 4'h0;
        illegal = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_TABLE[i]) begin
                nibble  = 4'(i);
                illegal = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sevenseg_capture.sv
// Recovers the four hex digits shown on a multiplexed, active-low
// seven-segment display by waiting for each scanned digit to be stable.
module sevenseg_capture
    import sevenseg_capture_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
)
(
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  enable,
    input  logic [6:0]  segs,
    input  logic        decimal,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  seen,
    output logic        digit_upd,
    output logic        frame_valid,
    output logic        err,
    output state_t      state
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    sample_t    sample;
    sample_t    prev;
    logic [7:0] count;
    logic [7:0] count_nxt;
    logic [3:0] mask;
    logic [3:0] mask_nxt;
    logic       same;
    logic       idle;
    logic       multi;
    logic       multi_prev;
    logic [1:0] idx;
    logic [3:0] nibble;
    logic       illegal;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sample <= SAMPLE_IDLE;
        end else begin
            sample <= {enable, segs, decimal};
        end
    end

    sevenseg_decode u_decode (
        .pattern (~sample.segs),
        .nibble  (nibble),
        .illegal (illegal)
    );

    always_comb begin
        same       = (sample == prev);
        idle       = (sample.enable == ENABLE_IDLE);
        multi      = !idle && !one_low(sample.enable);
        multi_prev = (prev.enable != ENABLE_IDLE) && !one_low(prev.enable);
        idx        = low_index(sample.enable);
        mask_nxt   = mask | (4'b0001 << idx);
        if (!same) begin
            count_nxt = 8'd1;
        end else if (count >= STABLE) begin
            count_nxt = STABLE;
        end else begin
            count_nxt = count + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state       <= ST_IDLE;
            prev        <= SAMPLE_IDLE;
            count       <= 8'd0;
            mask        <= 4'h0;
            digits      <= 16'h0000;
            dp          <= 4'h0;
            seen        <= 4'h0;
            digit_upd   <= 1'b0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            prev        <= sample;
            count       <= count_nxt;
            digit_upd   <= 1'b0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            if (idle) begin
                state <= ST_IDLE;
            end else if (multi) begin
                // Only the first cycle of an overlapping-enable episode is reported.
                state <= ST_IDLE;
                err   <= !multi_prev;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (count_nxt == STABLE) begin
                            state <= ST_HELD;
                            if (illegal) begin
                                err <= 1'b1;
                            end else begin
                                digits[{idx, 2'b00} +: 4] <= nibble;
                                dp[idx]                   <= ~sample.decimal;
                                seen[idx]                 <= 1'b1;
                                digit_upd                 <= 1'b1;
                                if (mask_nxt == 4'hF) begin
                                    frame_valid <= 1'b1;
                                    mask        <= 4'h0;
                                end else begin
                                    mask <= mask_nxt;
                                end
                            end
                        end
                    end
                    ST_HELD: begin
                        if (!same) begin
                            state <= ST_SETTLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
